// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : Multi-cycle Y86 memory stage. Decodes icode into a read/write,
//            runs a bounds precheck, drives a req/ack data-memory port with a
//            local timeout, and returns valM/dmem_error with a done pulse.
//            Optional macro MEM_ALIGN_CHECK_EN adds a natural-alignment check
//            to the precheck.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = 1024,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        icode_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic [DATA_W-1:0] valA_i,
  input  logic [ADDR_W-1:0] valP_i,
  output logic              done_o,
  output logic [DATA_W-1:0] valM_o,
  output logic              dmem_error_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_err_i
);

  // Instruction codes shared with the rest of the core
  localparam logic [3:0] c_IRMMOVQ = 4'h4;
  localparam logic [3:0] c_IMRMOVQ = 4'h5;
  localparam logic [3:0] c_ICALL   = 4'h8;
  localparam logic [3:0] c_IRET    = 4'h9;
  localparam logic [3:0] c_IPUSHQ  = 4'hA;
  localparam logic [3:0] c_IPOPQ   = 4'hB;

  localparam int c_WIDE_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int c_BYTES  = DATA_W / 8;
  localparam int c_CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_we;
  logic [DATA_W-1:0]  r_valm;
  logic               r_err;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_is_read;
  logic               w_is_write;
  logic [c_WIDE_W-1:0] w_valE_ext;
  logic [c_WIDE_W-1:0] w_valA_ext;
  logic [c_WIDE_W-1:0] w_valP_ext;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic [ADDR_W:0]    w_end;
  logic               w_pre_err;
  logic               w_timeout;

  // Decode direction, pick address/store operands and run the precheck
  always_comb begin
    w_valE_ext = c_WIDE_W'(valE_i);
    w_valA_ext = c_WIDE_W'(valA_i);
    w_valP_ext = c_WIDE_W'(valP_i);
    w_is_read  = (icode_i == c_IMRMOVQ) || (icode_i == c_IPOPQ) || (icode_i == c_IRET);
    w_is_write = (icode_i == c_IRMMOVQ) || (icode_i == c_IPUSHQ) || (icode_i == c_ICALL);
    // Pop and return address through the stack pointer carried on valA
    if ((icode_i == c_IPOPQ) || (icode_i == c_IRET)) begin
      w_addr = w_valA_ext[ADDR_W-1:0];
    end else begin
      w_addr = w_valE_ext[ADDR_W-1:0];
    end
    // Call pushes the return address; other stores push valA
    if (icode_i == c_ICALL) begin
      w_wdata = w_valP_ext[DATA_W-1:0];
    end else begin
      w_wdata = w_valA_ext[DATA_W-1:0];
    end
    // One extra bit keeps addresses near the top of the space from wrapping
    w_end     = {1'b0, w_addr} + (ADDR_W+1)'(c_BYTES);
    w_pre_err = (w_end > (ADDR_W+1)'(MEM_BYTES));
`ifdef MEM_ALIGN_CHECK_EN
    w_pre_err = w_pre_err || ((w_addr & ADDR_W'(c_BYTES - 1)) != '0);
`endif
  end

  assign w_timeout = (r_cnt == c_CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    ready_o   = 1'b0;
    done_o    = 1'b0;
    mem_req_o = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          if (!(w_is_read || w_is_write) || w_pre_err) begin
            w_next = ST_RESP;
          end else begin
            w_next = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        mem_req_o = 1'b1;
        // Ack is tested first so it wins over a same-cycle timeout
        if (mem_ack_i || w_timeout) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        done_o = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request latch, result capture and timeout counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_valm  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_i) begin
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_we    <= w_is_write;
            r_valm  <= '0;
            r_err   <= (w_is_read || w_is_write) && w_pre_err;
            r_cnt   <= '0;
          end
        end
        ST_ACCESS: begin
          if (mem_ack_i) begin
            if (!r_we) begin
              r_valm <= mem_rdata_i;
            end
            r_err <= mem_err_i;
          end else if (w_timeout) begin
            r_err  <= 1'b1;
            r_valm <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign valM_o       = r_valm;
  assign dmem_error_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit (defaults:
//            64-bit data/address, 1 KiB memory, TIMEOUT=16). Honours
//            MEM_ALIGN_CHECK_EN for the alignment case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  icode_i = 4'h0;
  logic [63:0] valE_i = '0;
  logic [63:0] valA_i = '0;
  logic [63:0] valP_i = '0;
  logic        done_o;
  logic [63:0] valM_o;
  logic        dmem_error_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [63:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_unit #(
    .DATA_W(64), .ADDR_W(64), .MEM_BYTES(1024), .TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .icode_i(icode_i), .valE_i(valE_i), .valA_i(valA_i), .valP_i(valP_i),
    .done_o(done_o), .valM_o(valM_o), .dmem_error_o(dmem_error_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
  );

  // Free-running clock, period 10
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation from IDLE. Cycle 0 is the accept cycle; ack is driven
  // during cycle ack_cyc (0 = never). Returns done latency in cycles and the
  // observed request/result values. Leaves the DUT back in IDLE.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] va, input logic [63:0] vp,
                        input int ack_cyc, input logic [63:0] rdata,
                        input logic merr,
                        output int lat, output int reqs,
                        output logic [63:0] addr, output logic we,
                        output logic [63:0] wdata, output logic [63:0] valm,
                        output logic err);
    bit got;
    got = 0; lat = 0; reqs = 0; addr = '0; we = 1'b0; wdata = '0; valm = '0; err = 1'b0;
    check("ready_before_accept", {63'd0, ready_o}, 64'd1);
    icode_i = ic; valE_i = ve; valA_i = va; valP_i = vp; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      mem_ack_i   = (c == ack_cyc);
      mem_rdata_i = rdata;
      mem_err_i   = merr;
      @(negedge clk_i);
      if (mem_req_o) begin
        reqs++;
        addr = mem_addr_o; we = mem_we_o; wdata = mem_wdata_o;
      end
      if (done_o) begin
        got = 1; lat = c; valm = valM_o; err = dmem_error_o;
      end
      @(posedge clk_i); #1;
    end
    mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    if (!got) check("done_within_budget", 64'd0, 64'd1);
  endtask

  int          lat, reqs, dcount;
  logic [63:0] addr, wdata, valm;
  logic        we, err;

  initial begin
    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_err", {63'd0, dmem_error_o}, 64'd0);
    check("rst_req", {63'd0, mem_req_o}, 64'd0);
    check("rst_we", {63'd0, mem_we_o}, 64'd0);
    check("rst_valm", valM_o, 64'd0);
    check("rst_addr", mem_addr_o, 64'd0);
    check("rst_wdata", mem_wdata_o, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("ready_after_rst", {63'd0, ready_o}, 64'd1);
    @(posedge clk_i); #1;

    // Read: IMRMOVQ 0x40, ack in third ACCESS cycle
    run_op(4'h5, 64'h40, 64'h0, 64'h0, 3, 64'h1122334455667788, 1'b0,
           lat, reqs, addr, we, wdata, valm, err);
    check("rd_lat", 64'(lat), 64'd4);
    check("rd_reqs", 64'(reqs), 64'd3);
    check("rd_addr", addr, 64'h40);
    check("rd_we", {63'd0, we}, 64'd0);
    check("rd_valm", valm, 64'h1122334455667788);
    check("rd_err", {63'd0, err}, 64'd0);
    check("rd_valm_hold", valM_o, 64'h1122334455667788);

    // Write: ICALL to 0x3F8 (last legal word), immediate ack
    run_op(4'h8, 64'h3F8, 64'h0, 64'h13, 1, 64'hDEAD, 1'b0,
           lat, reqs, addr, we, wdata, valm, err);
    check("wr_lat", 64'(lat), 64'd2);
    check("wr_reqs", 64'(reqs), 64'd1);
    check("wr_we", {63'd0, we}, 64'd1);
    check("wr_addr", addr, 64'h3F8);
    check("wr_wdata", wdata, 64'h13);
    check("wr_valm", valm, 64'd0);
    check("wr_err", {63'd0, err}, 64'd0);

    // Bounds: straddles the end of memory
    run_op(4'hA, 64'h3FC, 64'h55, 64'h0, 1, 64'h0, 1'b0,
           lat, reqs, addr, we, wdata, valm, err);
    check("oob_lat", 64'(lat), 64'd1);
    check("oob_reqs", 64'(reqs), 64'd0);
    check("oob_err", {63'd0, err}, 64'd1);

    // Bounds: address near 2^64 must not wrap into range
    run_op(4'hA, 64'hFFFFFFFFFFFFFFFC, 64'h55, 64'h0, 1, 64'h0, 1'b0,
           lat, reqs, addr, we, wdata, valm, err);
    check("wrap_lat", 64'(lat), 64'd1);
    check("wrap_reqs", 64'(reqs), 64'd0);
    check("wrap_err", {63'd0, err}, 64'd1);

    // Timeout: IPOPQ at 0x100, never acked
    run_op(4'hB, 64'h0, 64'h100, 64'h0, 0, 64'h0, 1'b0,
           lat, reqs, addr, we, wdata, valm, err);
    check("to_lat", 64'(lat), 64'd17);
    check("to_reqs", 64'(reqs), 64'd16);
    check("to_addr", addr, 64'h100);
    check("to_err", {63'd0, err}, 64'd1);
    check("to_valm", valm, 64'd0);

    // Memory-side error on a read, ack in second ACCESS cycle
    run_op(4'h5, 64'h0, 64'h0, 64'h0, 2, 64'hAB, 1'b1,
           lat, reqs, addr, we, wdata, valm, err);
    check("merr_lat", 64'(lat), 64'd3);
    check("merr_err", {63'd0, err}, 64'd1);
    check("merr_valm", valm, 64'hAB);

    // Non-memory IOPQ: clears previous results, no request
    run_op(4'h6, 64'h40, 64'h0, 64'h0, 1, 64'h0, 1'b0,
           lat, reqs, addr, we, wdata, valm, err);
    check("nop_lat", 64'(lat), 64'd1);
    check("nop_reqs", 64'(reqs), 64'd0);
    check("nop_err", {63'd0, err}, 64'd0);
    check("nop_valm", valm, 64'd0);

    // IRET abandoned by reset mid-ACCESS
    icode_i = 4'h9; valA_i = 64'h200; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_mid_req_before", {63'd0, mem_req_o}, 64'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_req_after", {63'd0, mem_req_o}, 64'd0);
    check("rst_mid_ready", {63'd0, ready_o}, 64'd1);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (done_o) dcount++;
      @(negedge clk_i);
    end
    check("rst_mid_no_done", 64'(dcount), 64'd0);
    @(posedge clk_i); #1;

    // Misaligned read at 0x44
    run_op(4'h5, 64'h44, 64'h0, 64'h0, 1, 64'h77, 1'b0,
           lat, reqs, addr, we, wdata, valm, err);
`ifdef MEM_ALIGN_CHECK_EN
    check("align_lat", 64'(lat), 64'd1);
    check("align_reqs", 64'(reqs), 64'd0);
    check("align_err", {63'd0, err}, 64'd1);
`else
    check("align_lat", 64'(lat), 64'd2);
    check("align_reqs", 64'(reqs), 64'd1);
    check("align_addr", addr, 64'h44);
    check("align_err", {63'd0, err}, 64'd0);
    check("align_valm", valm, 64'h77);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
